multicycle_control_fsm: RTL and testbench

//  Multicycle main controller for the 16-bit CPU. Sequences fetch/decode/execute/writeback and drives
//  the datapath strobes plus the 2-bit ALUOp consumed by the ALU control decoder. Handshakes with a

---
 rtl/multicycle_control_fsm_pkg.sv | 31 +++
 rtl/mc_ctrl_decode.sv | 68 ++++++
 rtl/multicycle_control_fsm.sv | 73 +++++++
 tb/tb_multicycle_control_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// cpu16_pkg: opcodes, controller states and datapath control encodings for the 16-bit CPU
package cpu16_pkg;
   localparam logic [3:0] OP_R0 = 4'b0000, OP_R1 = 4'b0001, OP_SHIFT = 4'b0010, OP_LW = 4'b0100,
                          OP_SW = 4'b0101, OP_BEQ = 4'b0110, OP_J = 4'b0111, OP_ADDI = 4'b1001,
                          OP_SUBI = 4'b1010, OP_SLTI = 4'b1011, OP_HALT = 4'b1111;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_R = 2'b10, ALU_I = 2'b11;
   localparam logic [1:0] SRCB_B = 2'b00, SRCB_TWO = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
   localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR, S_MEM_RD,
      S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP, S_HALT, S_BUS_ERR
   } state_t;
   // field order matches the top-level output port order
   typedef struct packed {
      logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
      logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       illegal_op, bus_err, halted;
   } ctrl_t;
   function automatic state_t dispatch(input logic [3:0] op);
      case (op)
         OP_R0, OP_R1:                      return S_R_EXEC;
         OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI: return S_I_EXEC;
         OP_LW, OP_SW:                      return S_MEM_ADDR;
         OP_BEQ:                            return S_BRANCH;
         OP_J:                              return S_JUMP;
         OP_HALT:                           return S_HALT;
         default:                           return S_TRAP;
      endcase
   endfunction
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: maps controller state (plus mem_ready in FETCH) to the datapath strobe vector
module mc_ctrl_decode
   import cpu16_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_TWO;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH;
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_R;
         end
         S_R_WB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_I_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_I;
         end
         S_I_WB:     ctrl.reg_write = 1'b1;
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_LW_WB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_JUMP;
         end
         S_TRAP:    ctrl.illegal_op = 1'b1;
         S_HALT:    ctrl.halted     = 1'b1;
         S_BUS_ERR: ctrl.bus_err    = 1'b1;
         default:   ctrl = '0;
      endcase
   end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: fetch/decode/execute/writeback sequencer with memory handshake and timeout
module multicycle_control_fsm
   import cpu16_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             illegal_op,
   output logic             bus_err,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);
   localparam logic [7:0] WLAST = 8'(WAIT_MAX - 1);
   state_t     state, next;
   logic [7:0] wcnt;
   logic       mem_st, timeout, retire, unused_zero;
   ctrl_t      ctrl, gated;
   assign unused_zero = zero;
   assign mem_st  = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   assign timeout = mem_st && !mem_ready && wcnt == WLAST;
   assign retire  = state inside {S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP} ||
                    (state == S_MEM_WR && mem_ready) || (state == S_DECODE && opcode == OP_HALT);
   always_comb begin
      next = state;
      case (state)
         S_FETCH:    next = mem_ready ? S_DECODE : timeout ? S_BUS_ERR : S_FETCH;
         S_DECODE:   next = dispatch(opcode);
         S_R_EXEC:   next = S_R_WB;
         S_I_EXEC:   next = S_I_WB;
         S_MEM_ADDR: next = opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   next = mem_ready ? S_LW_WB : timeout ? S_BUS_ERR : S_MEM_RD;
         S_MEM_WR:   next = mem_ready ? S_FETCH : timeout ? S_BUS_ERR : S_MEM_WR;
         S_BUS_ERR:  next = S_HALT;
         S_HALT:     next = S_HALT;
         default:    next = S_FETCH;
      endcase
   end
   // wait counter is zero whenever a memory state is entered, since every exit clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         wcnt        <= '0;
         instr_count <= '0;
      end else begin
         state <= next;
         wcnt  <= (mem_st && !mem_ready) ? wcnt + 8'd1 : 8'd0;
         if (retire) instr_count <= instr_count + CNT_W'(1);
      end
   end
   mc_ctrl_decode u_dec (.state(state), .mem_ready(mem_ready), .ctrl(ctrl));
   // the reset state is FETCH, so strobes are forced low while reset is held
   assign gated = rst_n ? ctrl : '0;
   assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, bus_err, halted} = gated;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-cycle model check of the multicycle controller with directed programs
module tb_multicycle_control_fsm;
   localparam int WM = 15;
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA},ALUSrcB,ALUOp,PCSource,{ill,berr,halt}
   localparam logic [18:0] W_FWAIT = {10'b0001000000, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_FDONE = {10'b1001010000, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_DEC   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_REX   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 3'b000};
   localparam logic [18:0] W_RWB   = {10'b0000000110, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_IEX   = {10'b0000000001, 2'b10, 2'b11, 2'b00, 3'b000};
   localparam logic [18:0] W_IWB   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_MADDR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_MRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_LWWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_MWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] W_BR    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b000};
   localparam logic [18:0] W_JMP   = {10'b1000000000, 2'b00, 2'b00, 2'b10, 3'b000};
   localparam logic [18:0] W_TRAP  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b100};
   localparam logic [18:0] W_BERR  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b010};
   localparam logic [18:0] W_HALT  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b001};

   logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic illegal_op, bus_err, halted;
   logic [3:0] instr_count;
   logic [18:0] act, exp_word;
   logic [3:0] exp_cnt, mcnt = 4'd0;
   logic exp_on = 1'b0, hlt = 1'b0, noise = 1'b0;
   int checks = 0, errors = 0, cyc = 0, lat;

   multicycle_control_fsm #(.CNT_W(4), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal_op(illegal_op), .bus_err(bus_err), .halted(halted),
      .instr_count(instr_count)
   );

   assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, bus_err, halted};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, a, e);
      end
   endtask

   always @(negedge clk) if (exp_on) begin
      chk("strobes", 32'(act), 32'(exp_word));
      chk("instr_count", 32'(instr_count), 32'(exp_cnt));
   end

   // one clock cycle: inputs and expectation set just after the edge, retire counted at the next edge
   task automatic step(input logic rdy, input logic [18:0] w, input logic inc);
      mem_ready = rdy;
      exp_word  = w;
      exp_cnt   = mcnt;
      exp_on    = 1'b1;
      cyc++;
      @(posedge clk);
      if (inc) mcnt++;
      #1 exp_on = 1'b0;
   endtask

   task automatic instr(input logic [3:0] op, input int fw, input int mw, output int l);
      int c0;
      logic [18:0] mword;
      c0 = cyc;
      opcode = op;
      l = 0;
      if (fw >= WM) begin
         repeat (WM) step(1'b0, W_FWAIT, 1'b0);
         step(noise, W_BERR, 1'b0);
         hlt = 1'b1;
         l = cyc - c0;
         return;
      end
      repeat (fw) step(1'b0, W_FWAIT, 1'b0);
      step(1'b1, W_FDONE, 1'b0);
      step(noise, W_DEC, op == 4'hF);
      if (op inside {4'h0, 4'h1}) begin
         step(noise, W_REX, 1'b0);
         step(noise, W_RWB, 1'b1);
      end else if (op inside {4'h2, 4'h9, 4'hA, 4'hB}) begin
         step(noise, W_IEX, 1'b0);
         step(noise, W_IWB, 1'b1);
      end else if (op inside {4'h4, 4'h5}) begin
         mword = (op == 4'h4) ? W_MRD : W_MWR;
         step(noise, W_MADDR, 1'b0);
         if (mw >= WM) begin
            repeat (WM) step(1'b0, mword, 1'b0);
            step(noise, W_BERR, 1'b0);
            hlt = 1'b1;
         end else begin
            repeat (mw) step(1'b0, mword, 1'b0);
            step(1'b1, mword, op == 4'h5);
            if (op == 4'h4) step(noise, W_LWWB, 1'b1);
         end
      end else if (op == 4'h6) step(noise, W_BR, 1'b1);
      else if (op == 4'h7) step(noise, W_JMP, 1'b1);
      else if (op == 4'hF) hlt = 1'b1;
      else step(noise, W_TRAP, 1'b0);
      l = cyc - c0;
   endtask

   task automatic idle_halted(input int n);
      repeat (n) step(noise, W_HALT, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("reset_strobes", 32'(act), 32'd0);
      chk("reset_count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mcnt = 4'd0;
      hlt = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      do_reset();
      instr(4'h1, 0, 0, lat);  chk("add_latency", lat, 4);  chk("add_count", 32'(mcnt), 1);
      instr(4'h9, 1, 0, lat);  chk("addi_latency", lat, 5);
      instr(4'h4, 0, 3, lat);  chk("lw_wait3_latency", lat, 8); chk("lw_count", 32'(mcnt), 3);
      instr(4'h5, 0, 0, lat);  chk("sw_latency", lat, 4);
      noise = 1'b1;
      zero = 1'b1;
      instr(4'h6, 0, 0, lat);  chk("beq_latency", lat, 3);
      zero = 1'b0;
      instr(4'h7, 0, 0, lat);  chk("j_latency", lat, 3);
      instr(4'hC, 0, 0, lat);  chk("trap_latency", lat, 3); chk("trap_count", 32'(mcnt), 6);
      instr(4'h0, 0, 0, lat);
      instr(4'h2, 2, 0, lat);
      instr(4'hA, 0, 0, lat);
      instr(4'hB, 0, 0, lat);
      instr(4'h3, 0, 0, lat);
      instr(4'h8, 0, 0, lat);
      noise = 1'b0;
      instr(4'h1, WM - 1, 0, lat); chk("fetch_ready_at_limit", lat, 4 + WM - 1);
      instr(4'h4, 0, WM - 1, lat); chk("mem_ready_at_limit", lat, 5 + WM - 1);
      do_reset();
      repeat (15) instr(4'h7, 0, 0, lat);
      chk("count_15", 32'(mcnt), 15);
      instr(4'h7, 0, 0, lat);
      step(1'b0, W_FWAIT, 1'b0);
      chk("count_wrap", 32'(instr_count), 0);
      do_reset();
      instr(4'h1, 0, 0, lat);
      opcode = 4'h5;
      step(1'b1, W_FDONE, 1'b0);
      step(1'b0, W_DEC, 1'b0);
      step(1'b0, W_MADDR, 1'b0);
      step(1'b0, W_MWR, 1'b0);
      mem_ready = 1'b0;
      #1 chk("memwrite_before_reset", 32'(MemWrite), 1);
      #1 rst_n = 1'b0;
      #1 chk("memwrite_async_drop", 32'(MemWrite), 0);
      chk("count_async_clear", 32'(instr_count), 0);
      chk("strobes_async_clear", 32'(act), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mcnt = 4'd0;
      instr(4'h1, 0, 0, lat);
      noise = 1'b1;
      instr(4'h1, WM, 0, lat); chk("fetch_timeout_latency", lat, WM + 1);
      idle_halted(3);
      chk("halted_after_timeout", 32'(halted), 1);
      do_reset();
      instr(4'h4, 0, WM, lat);
      idle_halted(2);
      do_reset();
      instr(4'hF, 0, 0, lat);
      idle_halted(4);
      chk("halt_counts_once", 32'(instr_count), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
